// File: rtl/bp_pkg.sv
// ============================================================================
// bp_pkg: shared branch-predictor types, counter init value and helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bp_pkg;

    typedef struct packed {
        logic        en;
        logic [31:0] pc;
        logic        actual_taken;
    } bp_update_t;

    typedef logic [1:0] bp_ctr_t;

    typedef enum logic [0:0] {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_t;

    localparam bp_ctr_t BP_CTR_INIT = 2'b01;

    function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t c, input logic taken);
        bp_ctr_t n;
        n = c;
        if (taken) begin
            if (c != 2'b11) n = c + 2'b01;
        end else begin
            if (c != 2'b00) n = c - 2'b01;
        end
        return n;
    endfunction

    // Word-aligned PC bits, optionally folded with the next IDX_W bits up.
    function automatic logic [31:0] bp_index(input logic [31:0] pc, input int idx_w,
                                             input bit hash_upper);
        logic [31:0] mask;
        logic [31:0] lo;
        logic [31:0] hi;
        mask = (32'd1 << idx_w) - 32'd1;
        lo   = (pc >> 2) & mask;
        hi   = (pc >> (idx_w + 2)) & mask;
        return hash_upper ? (lo ^ hi) : lo;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_counter_table.sv
// ============================================================================
// bp_counter_table: 2-bit counter array with query/update read ports and the
// INIT sweep state machine. Revision: 1.0
// ============================================================================
`default_nettype none

module bp_counter_table
    import bp_pkg::*;
#(
    parameter int NUM_ENTRIES = 256,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [IDX_W-1:0] query_idx,
    output logic             query_pred,
    input  logic [IDX_W-1:0] s2_idx,
    output bp_ctr_t          s2_ctr,
    input  logic             wr_en,
    input  bp_ctr_t          wr_data,
    output logic             ready
);

    bp_ctr_t          mem [NUM_ENTRIES];
    bp_state_t        state;
    bp_state_t        state_next;
    logic [IDX_W-1:0] sweep_idx;
    logic [IDX_W-1:0] sweep_next;
    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;
    bp_ctr_t          mem_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BP_INIT;
            sweep_idx <= '0;
        end else begin
            state     <= state_next;
            sweep_idx <= sweep_next;
        end
    end

    always_comb begin
        state_next = state;
        sweep_next = sweep_idx;
        case (state)
            BP_INIT: begin
                if (flush) begin
                    sweep_next = '0;
                end else if (sweep_idx == IDX_W'(NUM_ENTRIES - 1)) begin
                    state_next = BP_RUN;
                    sweep_next = '0;
                end else begin
                    sweep_next = sweep_idx + 1'b1;
                end
            end
            BP_RUN: begin
                if (flush) begin
                    state_next = BP_INIT;
                    sweep_next = '0;
                end
            end
            default: begin
                state_next = BP_INIT;
                sweep_next = '0;
            end
        endcase
    end

    // The sweep owns the write port while initialising.
    always_comb begin
        mem_we    = wr_en;
        mem_widx  = s2_idx;
        mem_wdata = wr_data;
        if (state == BP_INIT) begin
            mem_we    = 1'b1;
            mem_widx  = sweep_idx;
            mem_wdata = BP_CTR_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

    assign query_pred = mem[query_idx][1];
    assign s2_ctr     = mem[s2_idx];
    assign ready      = (state == BP_RUN);

endmodule

`default_nettype wire

// File: rtl/branch_history_table.sv
// ============================================================================
// branch_history_table: trains 2-bit counters from bp_update, answers
// same-cycle prediction queries with S1 forwarding, keeps statistics.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_history_table
    import bp_pkg::*;
#(
    parameter int NUM_ENTRIES = 256,
    parameter int HASH_UPPER  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  bp_update_t  bp_update,
    input  logic [31:0] query_pc,
    input  logic        query_valid,
    output logic        pred_taken,
    output logic        ready,
    input  logic        flush,
    output logic [31:0] upd_count,
    output logic [31:0] mispred_count,
    output logic [15:0] drop_count
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] query_idx;
    logic [IDX_W-1:0] s1_idx;
    logic             s1_valid;
    logic             s1_taken;
    logic             query_pred;
    bp_ctr_t          s2_ctr;
    bp_ctr_t          s2_next;
    logic             accept;
    logic             s2_fire;
    logic             fwd_hit;
    logic             unused_query_valid;

    assign upd_idx   = IDX_W'(bp_index(bp_update.pc, IDX_W, HASH_UPPER != 0));
    assign query_idx = IDX_W'(bp_index(query_pc, IDX_W, HASH_UPPER != 0));

    // Queries have no side effects; the qualifier is only carried for callers.
    assign unused_query_valid = query_valid;

    assign accept  = bp_update.en && ready && !flush;
    assign s2_fire = s1_valid && !flush;
    assign s2_next = bp_ctr_next(s2_ctr, s1_taken);
    assign fwd_hit = s1_valid && (query_idx == s1_idx);

    bp_counter_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .query_idx  (query_idx),
        .query_pred (query_pred),
        .s2_idx     (s1_idx),
        .s2_ctr     (s2_ctr),
        .wr_en      (s2_fire),
        .wr_data    (s2_next),
        .ready      (ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_taken <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_idx   <= upd_idx;
                s1_taken <= bp_update.actual_taken;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_count     <= '0;
            mispred_count <= '0;
            drop_count    <= '0;
        end else begin
            if (s2_fire) begin
                upd_count <= upd_count + 32'd1;
                if (s2_ctr[1] != s1_taken) mispred_count <= mispred_count + 32'd1;
            end
            if (bp_update.en && !accept) drop_count <= drop_count + 16'd1;
        end
    end

    // Forwarding returns the post-update prediction while S2 is still in flight.
    always_comb begin
        pred_taken = 1'b0;
        if (ready) pred_taken = fwd_hit ? s2_next[1] : query_pred;
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_history_table.sv
// ============================================================================
// tb_branch_history_table: vector table, hand sequences and random traffic
// against a behavioural model, on a direct and a hashed instance. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_history_table;
    import bp_pkg::*;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        query_valid = 1'b1;
    bp_update_t  bp_update = '0;
    logic [31:0] query_pc = '0;
    logic        pred0, pred1, ready0, ready1;
    logic [31:0] upd0, upd1, mis0, mis1;
    logic [15:0] drop0, drop1;

    always #5 clk = ~clk;

    branch_history_table #(.NUM_ENTRIES(N), .HASH_UPPER(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bp_update(bp_update), .query_pc(query_pc),
        .query_valid(query_valid), .pred_taken(pred0), .ready(ready0), .flush(flush),
        .upd_count(upd0), .mispred_count(mis0), .drop_count(drop0)
    );

    branch_history_table #(.NUM_ENTRIES(N), .HASH_UPPER(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bp_update(bp_update), .query_pc(query_pc),
        .query_valid(query_valid), .pred_taken(pred1), .ready(ready1), .flush(flush),
        .upd_count(upd1), .mispred_count(mis1), .drop_count(drop1)
    );

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counters as small integers, one pending update
    int m_ctr [2][N];
    int m_left;
    bit m_pv;
    int m_pidx [2];
    bit m_ptk;
    int m_upd;
    int m_mis [2];
    int m_drop;

    function automatic int m_index(input int d, input logic [31:0] pc);
        int lo;
        int hi;
        lo = int'((pc / 4) % N);
        hi = int'((pc / 64) % N);
        return (d != 0) ? (lo ^ hi) : lo;
    endfunction

    function automatic int m_sat(input int c, input bit tk);
        if (tk) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    function automatic bit m_pred(input int d, input logic [31:0] qpc);
        int i;
        int c;
        if (m_left > 0) return 1'b0;
        i = m_index(d, qpc);
        c = m_ctr[d][i];
        if (m_pv && m_pidx[d] == i) c = m_sat(c, m_ptk);
        return c >= 2;
    endfunction

    task automatic m_fill();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < N; i++) m_ctr[d][i] = 1;
    endtask

    task automatic m_reset();
        m_fill();
        m_left = N;
        m_pv   = 1'b0;
        m_upd  = 0;
        m_mis[0] = 0;
        m_mis[1] = 0;
        m_drop = 0;
    endtask

    task automatic m_step();
        if (m_left > 0) begin
            if (bp_update.en) m_drop++;
            m_left = flush ? N : m_left - 1;
            m_pv = 1'b0;
        end else if (flush) begin
            if (bp_update.en) m_drop++;
            m_pv = 1'b0;
            m_left = N;
            m_fill();
        end else begin
            if (m_pv) begin
                m_upd++;
                for (int d = 0; d < 2; d++) begin
                    if ((m_ctr[d][m_pidx[d]] >= 2) != m_ptk) m_mis[d]++;
                    m_ctr[d][m_pidx[d]] = m_sat(m_ctr[d][m_pidx[d]], m_ptk);
                end
            end
            m_pv = bp_update.en;
            m_ptk = bp_update.actual_taken;
            for (int d = 0; d < 2; d++) m_pidx[d] = m_index(d, bp_update.pc);
        end
    endtask

    task automatic chk_model();
        chk("pred_h0", 32'(pred0), 32'(m_pred(0, query_pc)));
        chk("pred_h1", 32'(pred1), 32'(m_pred(1, query_pc)));
        chk("ready", 32'(ready0), 32'(m_left == 0));
        chk("ready_h1", 32'(ready1), 32'(m_left == 0));
        chk("upd_count", upd0, 32'(m_upd));
        chk("upd_count_h1", upd1, 32'(m_upd));
        chk("mispred_h0", mis0, 32'(m_mis[0]));
        chk("mispred_h1", mis1, 32'(m_mis[1]));
        chk("drop_count", 32'(drop0), 32'(m_drop & 32'hFFFF));
        chk("drop_count_h1", 32'(drop1), 32'(m_drop & 32'hFFFF));
    endtask

    task automatic drive(input logic en, input logic [31:0] pc, input logic tk,
                         input logic [31:0] qpc, input logic fl);
        @(negedge clk);
        bp_update.en = en;
        bp_update.pc = pc;
        bp_update.actual_taken = tk;
        query_pc = qpc;
        flush = fl;
        #1;
        chk_model();
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
    endtask

    task automatic init_wait(input int drop_at);
        for (int i = 0; i < N; i++) begin
            drive(i == drop_at, 32'h100, 1'b1, 32'h40, 1'b0);
            chk("init_ready_low", 32'(ready0), 32'd0);
            chk("init_pred_zero", 32'(pred0), 32'd0);
            tick();
        end
    endtask

    typedef struct {
        logic        en;
        logic [31:0] pc;
        logic        tk;
        logic [31:0] qpc;
        logic        fl;
        logic        pred;
        logic [31:0] upd;
        logic [31:0] mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic [31:0] pc, input logic tk,
                                input logic [31:0] qpc, input logic fl, input logic pred,
                                input int upd, input int mis);
        vec_t v;
        v.en = en; v.pc = pc; v.tk = tk; v.qpc = qpc; v.fl = fl;
        v.pred = pred; v.upd = 32'(upd); v.mis = 32'(mis);
        return v;
    endfunction

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            drive(vecs[i].en, vecs[i].pc, vecs[i].tk, vecs[i].qpc, vecs[i].fl);
            chk($sformatf("vec%0d_pred", i), 32'(pred0), 32'(vecs[i].pred));
            chk($sformatf("vec%0d_upd", i), upd0, vecs[i].upd);
            chk($sformatf("vec%0d_mis", i), mis0, vecs[i].mis);
            tick();
        end
    endtask

    initial begin
        // forwarding, no-forward neighbour, then flush cancelling a pending S2
        vecs.push_back(mk(1, 32'h80, 1, 32'h80, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h00, 0, 32'h80, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h80, 1, 32'h84, 0, 0, 1, 1));
        vecs.push_back(mk(0, 32'h00, 0, 32'h84, 0, 0, 1, 1));
        vecs.push_back(mk(1, 32'h80, 0, 32'h80, 0, 1, 2, 1));
        vecs.push_back(mk(0, 32'h00, 0, 32'h80, 1, 1, 2, 1));
        // taken x2 then not-taken x4 on a freshly initialised table
        vecs.push_back(mk(1, 32'h40, 1, 32'h40, 0, 0, 2, 1));
        vecs.push_back(mk(0, 32'h00, 0, 32'h40, 0, 1, 2, 1));
        vecs.push_back(mk(1, 32'h40, 1, 32'h40, 0, 1, 3, 2));
        vecs.push_back(mk(0, 32'h00, 0, 32'h40, 0, 1, 3, 2));
        vecs.push_back(mk(0, 32'h00, 0, 32'h40, 0, 1, 4, 2));
        vecs.push_back(mk(1, 32'h40, 0, 32'h40, 0, 1, 4, 2));
        vecs.push_back(mk(0, 32'h00, 0, 32'h40, 0, 1, 4, 2));
        vecs.push_back(mk(1, 32'h40, 0, 32'h40, 0, 1, 5, 3));
        vecs.push_back(mk(0, 32'h00, 0, 32'h40, 0, 0, 5, 3));
        vecs.push_back(mk(1, 32'h40, 0, 32'h40, 0, 0, 6, 4));
        vecs.push_back(mk(0, 32'h00, 0, 32'h40, 0, 0, 6, 4));
        vecs.push_back(mk(1, 32'h40, 0, 32'h40, 0, 0, 7, 4));
        vecs.push_back(mk(0, 32'h00, 0, 32'h40, 0, 0, 7, 4));
        vecs.push_back(mk(0, 32'h00, 0, 32'h40, 0, 0, 8, 4));

        m_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready0), 32'd0);
        chk("rst_pred", 32'(pred0), 32'd0);
        chk("rst_upd", upd0, 32'd0);
        chk("rst_mis", mis0, 32'd0);
        chk("rst_drop", 32'(drop0), 32'd0);

        // sweep length after reset release
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (i > 0) @(negedge clk);
            query_pc = 32'(i * 4);
            #1;
            chk_model();
            chk("t1_ready_low", 32'(ready0), 32'd0);
            tick();
        end
        for (int i = 0; i < N; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'(i * 4), 1'b0);
            chk("t1_ready_high", 32'(ready0), 32'd1);
            chk("t1_pred_init", 32'(pred0), 32'd0);
            tick();
        end

        run_vecs(0, 6);
        init_wait(3);
        drive(1'b0, 32'h0, 1'b0, 32'h80, 1'b0);
        chk("t5_ready_back", 32'(ready0), 32'd1);
        chk("t5_drop", 32'(drop0), 32'd1);
        chk("t5_upd_kept", upd0, 32'd2);
        chk("t5_ctr_reinit", 32'(pred0), 32'd0);
        tick();
        run_vecs(6, vecs.size());

        // direct index aliases 0x04/0x44, hashed index separates them
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        init_wait(-1);
        drive(1'b1, 32'h04, 1'b1, 32'h44, 1'b0);
        chk("t6_pre_h0", 32'(pred0), 32'd0);
        chk("t6_pre_h1", 32'(pred1), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h44, 1'b0);
        chk("t6_fwd_alias_h0", 32'(pred0), 32'd1);
        chk("t6_fwd_sep_h1", 32'(pred1), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h44, 1'b0);
        chk("t6_alias_h0", 32'(pred0), 32'd1);
        chk("t6_sep_h1", 32'(pred1), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h04, 1'b0);
        chk("t6_trained_h1", 32'(pred1), 32'd1);
        tick();

        // random traffic over a narrow PC window to provoke aliasing and back-to-back hits
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom & 32'h3FC, 1'($urandom_range(0, 1)),
                  $urandom & 32'h3FC, $urandom_range(0, 99) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

`default_nettype wire
